// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller: a timed Moore FSM drives the NS/EW {R,Y,G} codes.
// A free-running scan select time-multiplexes both codes onto one shared LED bank.
module traffic_light_ctrl #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int SCAN_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       scan_sel,
    output logic       cycle_end
);

    localparam int MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int MAX_DUR = (MAX_GY > ALLRED_CYC) ? MAX_GY : ALLRED_CYC;
    localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        ALL_RED1,
        EW_GREEN,
        EW_YELLOW,
        ALL_RED2
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pedPending_q, pedPending_d;
    logic            cycleEnd_q, cycleEnd_d;
    logic [2:0]      nsLight_q, nsLight_d;
    logic [2:0]      ewLight_q, ewLight_d;
    logic [SW-1:0]   scanCnt_q;
    logic            scanSel_q;
    logic            isGreen;

    function automatic state_e nextState(input state_e s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED1;
            ALL_RED1:  return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return ALL_RED2;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [TW-1:0] loadValue(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   return TW'(GREEN_CYC - 1);
            NS_YELLOW, EW_YELLOW: return TW'(YELLOW_CYC - 1);
            default:              return TW'(ALLRED_CYC - 1);
        endcase
    endfunction

    function automatic logic [2:0] nsCode(input state_e s);
        case (s)
            NS_GREEN:  return GREEN;
            NS_YELLOW: return YELLOW;
            default:   return RED;
        endcase
    endfunction

    function automatic logic [2:0] ewCode(input state_e s);
        case (s)
            EW_GREEN:  return GREEN;
            EW_YELLOW: return YELLOW;
            default:   return RED;
        endcase
    endfunction

    assign isGreen = (state_q == NS_GREEN) || (state_q == EW_GREEN);

    // Lights are decoded from the next state so they register on the same edge as the state.
    // A pedestrian request arriving on the clearing edge into all-red wins over the clear.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pedPending_d = pedPending_q | ped_req;
        cycleEnd_d   = 1'b0;
        if (en) begin
            if (timer_q == '0) begin
                state_d    = nextState(state_q);
                timer_d    = loadValue(state_d);
                cycleEnd_d = (state_q == ALL_RED2);
                if ((state_d == ALL_RED1) || (state_d == ALL_RED2)) begin
                    pedPending_d = ped_req;
                end
            end else if (isGreen && pedPending_q && (timer_q > TW'(1))) begin
                timer_d = TW'(1);
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
        nsLight_d = nsCode(state_d);
        ewLight_d = ewCode(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ALL_RED2;
            timer_q      <= TW'(ALLRED_CYC - 1);
            pedPending_q <= 1'b0;
            cycleEnd_q   <= 1'b0;
            nsLight_q    <= RED;
            ewLight_q    <= RED;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pedPending_q <= pedPending_d;
            cycleEnd_q   <= cycleEnd_d;
            nsLight_q    <= nsLight_d;
            ewLight_q    <= ewLight_d;
        end
    end

    // Scan select runs every clock, independent of the phase enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanCnt_q <= '0;
            scanSel_q <= 1'b0;
        end else if (scanCnt_q == SW'(SCAN_DIV - 1)) begin
            scanCnt_q <= '0;
            scanSel_q <= ~scanSel_q;
        end else begin
            scanCnt_q <= scanCnt_q + SW'(1);
        end
    end

    assign ns_light  = nsLight_q;
    assign ew_light  = ewLight_q;
    assign scan_sel  = scanSel_q;
    assign cycle_end = cycleEnd_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed phase scenarios plus random en/ped_req
// traffic, compared every cycle against a phase-table reference model.
module tb_traffic_light_ctrl;

    localparam int GREEN_CYC  = 8;
    localparam int YELLOW_CYC = 2;
    localparam int ALLRED_CYC = 1;
    localparam int SCAN_DIV   = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       scan_sel;
    logic       cycle_end;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index 0..5 (NSG, NSY, AR1, EWG, EWY, AR2) and enabled cycles left.
    int mPhase;
    int mLeft;
    int mScanClk;
    bit mPend;
    bit mCycleEnd;

    traffic_light_ctrl #(
        .GREEN_CYC (GREEN_CYC),
        .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .scan_sel (scan_sel),
        .cycle_end(cycle_end)
    );

    always #5 clk = ~clk;

    function automatic int phaseLen(input int p);
        case (p)
            0, 3:    return GREEN_CYC;
            1, 4:    return YELLOW_CYC;
            default: return ALLRED_CYC;
        endcase
    endfunction

    function automatic logic [2:0] expNs(input int p);
        if (p == 0) return 3'b001;
        if (p == 1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] expEw(input int p);
        if (p == 3) return 3'b001;
        if (p == 4) return 3'b010;
        return 3'b100;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase    = 5;
        mLeft     = ALLRED_CYC;
        mPend     = 1'b0;
        mScanClk  = 0;
        mCycleEnd = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic modelEdge();
        mScanClk++;
        mCycleEnd = 1'b0;
        if (en) begin
            if (mLeft == 1) begin
                mCycleEnd = (mPhase == 5);
                mPhase    = (mPhase + 1) % 6;
                mLeft     = phaseLen(mPhase);
                if (mPhase == 2 || mPhase == 5) mPend = ped_req;
                else mPend = mPend | ped_req;
            end else begin
                if ((mPhase == 0 || mPhase == 3) && mPend && mLeft > 2) mLeft = 2;
                else mLeft--;
                mPend = mPend | ped_req;
            end
        end else begin
            mPend = mPend | ped_req;
        end
    endtask

    task automatic compareAll();
        logic       expSel;
        logic [2:0] expMux;
        logic [2:0] dutMux;
        expSel = 1'(((mScanClk / SCAN_DIV) % 2));
        expMux = expSel ? expEw(mPhase) : expNs(mPhase);
        dutMux = scan_sel ? ew_light : ns_light;
        checkOutput("ns_light", 32'(ns_light), 32'(expNs(mPhase)));
        checkOutput("ew_light", 32'(ew_light), 32'(expEw(mPhase)));
        checkOutput("scan_sel", 32'(scan_sel), 32'(expSel));
        checkOutput("cycle_end", 32'(cycle_end), 32'(mCycleEnd));
        checkOutput("mux_out", 32'(dutMux), 32'(expMux));
    endtask

    task automatic applyStimulus(input bit enV, input bit pedV);
        en      = enV;
        ped_req = pedV;
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    // Counts consecutive cycles (en=1) the DUT shows the given light pair.
    task automatic measure(input logic [2:0] nsCode, input logic [2:0] ewCode, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (ns_light !== nsCode || ew_light !== ewCode) break;
            n++;
            applyStimulus(1'b1, 1'b0);
        end
    endtask

    task automatic runPeriods(input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 2 * 2 * (GREEN_CYC + YELLOW_CYC + ALLRED_CYC); i++) begin
            applyStimulus(1'b1, 1'b0);
            if (cycle_end === 1'b1) pulses++;
        end
        checkOutput(tag, 32'(pulses), 32'd2);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ns"}, 32'(ns_light), 32'h4);
        checkOutput({tag, "_ew"}, 32'(ew_light), 32'h4);
        checkOutput({tag, "_scan"}, 32'(scan_sel), 32'h0);
        checkOutput({tag, "_ce"}, 32'(cycle_end), 32'h0);
    endtask

    initial begin
        int n;
        bit reached;

        $display("[TB] start");
        #1 rst_n = 1'b0;
        #2;
        checkResetOutputs("reset");
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full default sequence twice: one cycle_end pulse per 22-cycle period.
        runPeriods("ce_pulses_run1");

        // Pedestrian pulse in the third NS green cycle shortens NS green to 6.
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mPhase == 0 && mLeft == GREEN_CYC - 2) begin reached = 1'b1; break; end
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("reach_ns_g3", 32'(reached), 32'd1);
        applyStimulus(1'b1, 1'b1);
        measure(3'b001, 3'b100, n);
        checkOutput("ped_ns_green_len", 32'(n + 3), 32'(GREEN_CYC - 2));
        measure(3'b010, 3'b100, n);
        checkOutput("ped_ns_yellow_len", 32'(n), 32'(YELLOW_CYC));
        measure(3'b100, 3'b100, n);
        checkOutput("ped_allred1_len", 32'(n), 32'(ALLRED_CYC));
        measure(3'b100, 3'b001, n);
        checkOutput("ped_ew_green_full", 32'(n), 32'(GREEN_CYC));

        // Request held across the AR1 entry keeps the flag; the first EW green edge then loads 1,
        // so EW green shows for that first cycle plus two more.
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mPhase == 1 && mLeft == 1) begin reached = 1'b1; break; end
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("reach_ns_y_last", 32'(reached), 32'd1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        measure(3'b100, 3'b001, n);
        checkOutput("held_ew_green_len", 32'(n), 32'd3);

        // Freeze for 5 cycles mid EW green; total enabled green length stays 8.
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mPhase == 3 && mLeft == GREEN_CYC - 3) begin reached = 1'b1; break; end
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("reach_ew_g4", 32'(reached), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        measure(3'b100, 3'b001, n);
        checkOutput("frozen_ew_green_rest", 32'(n), 32'(GREEN_CYC - 3));

        // Random enable and pedestrian traffic.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset in the middle of NS yellow.
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mPhase == 1) begin reached = 1'b1; break; end
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("reach_ns_yellow", 32'(reached), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        modelReset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        runPeriods("ce_pulses_run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
